// File: rtl/mips_tb_program_monitor.sv
// Loadable program ROM and run monitor for directed Harvard-CPU tests.
// Serves fetches from a DEPTH-word image at RESET_VECTOR and grades the run by halt, timeout or bad fetch.
module mips_tb_program_monitor #(
   parameter int unsigned DEPTH         = 64,
   parameter logic [31:0] RESET_VECTOR  = 32'hBFC00000,
   parameter int unsigned TIMEOUT       = 1000,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              instr_address,
   output logic [31:0]              instr_readdata,
   input  logic [31:0]              register_v0,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_index,
   input  logic [31:0]              load_data,
   input  logic [31:0]              expected_v0,
   input  logic                     start,
   output logic                     running,
   output logic                     done,
   output logic                     pass,
   output logic [1:0]               fail_code,
   output logic [CNT_W-1:0]         cycle_count,
   output logic [CNT_W-1:0]         fetch_count
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned SW    = $clog2(SETTLE_CYCLES) + 1;

   localparam logic [31:0]      WIN_BYTES   = 32'(4 * DEPTH);
   localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT - 1);
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RUN    = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_PASS   = 3'd3;
   localparam logic [2:0] S_FAIL   = 3'd4;

   logic [2:0]       state;
   logic [31:0]      mem [DEPTH];
   logic [31:0]      exp_v0;
   logic [31:0]      prev_addr;
   logic [SW-1:0]    settle_cnt;
   logic [31:0]      offset;
   logic             in_window;
   logic [IDX_W-1:0] rd_index;
   logic             idle_like;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Unsigned wrap makes addresses below RESET_VECTOR land far outside the window.
   assign offset    = instr_address - RESET_VECTOR;
   assign in_window = (offset < WIN_BYTES) && (offset[1:0] == 2'b00);
   assign rd_index  = offset[IDX_W+1:2];

   assign instr_readdata = (reset && in_window) ? mem[rd_index] : 32'h0;

   assign idle_like = (state == S_IDLE) || (state == S_PASS) || (state == S_FAIL);
   assign running   = (state == S_RUN) || (state == S_SETTLE);
   assign done      = (state == S_PASS) || (state == S_FAIL);
   assign pass      = (state == S_PASS);

   always_ff @(posedge clk) begin
      if (load_en && idle_like) begin
         mem[load_index] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (start && idle_like) begin
         exp_v0 <= expected_v0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         fail_code   <= 2'd0;
         cycle_count <= '0;
         fetch_count <= '0;
         prev_addr   <= 32'h0;
         settle_cnt  <= '0;
      end else begin
         prev_addr <= instr_address;
         case (state)
            S_IDLE, S_PASS, S_FAIL: begin
               if (start) begin
                  state       <= S_RUN;
                  fail_code   <= 2'd0;
                  cycle_count <= '0;
                  fetch_count <= '0;
               end
            end
            S_RUN: begin
               if (instr_address != prev_addr) begin
                  fetch_count <= sat_inc(fetch_count);
               end
               // Halt beats bad-fetch, which beats timeout.
               if (instr_address == 32'h0) begin
                  state      <= S_SETTLE;
                  settle_cnt <= '0;
               end else if (!in_window) begin
                  state     <= S_FAIL;
                  fail_code <= 2'd3;
               end else if (cycle_count == TO_LAST) begin
                  state     <= S_FAIL;
                  fail_code <= 2'd2;
               end else begin
                  cycle_count <= sat_inc(cycle_count);
               end
            end
            S_SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  if (register_v0 == exp_v0) begin
                     state <= S_PASS;
                  end else begin
                     state     <= S_FAIL;
                     fail_code <= 2'd1;
                  end
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_tb_program_monitor.sv
// Directed bench for mips_tb_program_monitor: read-path vector table, fetch scoreboard and run scenarios.
module tb_mips_tb_program_monitor;

   localparam int unsigned DEPTH         = 16;
   localparam logic [31:0] RV            = 32'hBFC00000;
   localparam int unsigned TIMEOUT       = 50;
   localparam int unsigned SETTLE_CYCLES = 2;
   localparam int unsigned CNT_W         = 16;
   localparam logic [31:0] J_SELF        = 32'h0BF00000;
   localparam logic [31:0] MARKER        = 32'hA5A50F0F;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [31:0]              instr_address;
   logic [31:0]              instr_readdata;
   logic [31:0]              register_v0;
   logic                     load_en;
   logic [$clog2(DEPTH)-1:0] load_index;
   logic [31:0]              load_data;
   logic [31:0]              expected_v0;
   logic                     start;
   logic                     running;
   logic                     done;
   logic                     pass;
   logic [1:0]               fail_code;
   logic [CNT_W-1:0]         cycle_count;
   logic [CNT_W-1:0]         fetch_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] prog [8];
   logic [31:0] sb_q [$];

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] data;
   } rd_vec_t;

   rd_vec_t vecs [7];

   mips_tb_program_monitor #(
      .DEPTH(DEPTH), .RESET_VECTOR(RV), .TIMEOUT(TIMEOUT),
      .SETTLE_CYCLES(SETTLE_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .instr_address(instr_address), .instr_readdata(instr_readdata),
      .register_v0(register_v0),
      .load_en(load_en), .load_index(load_index), .load_data(load_data),
      .expected_v0(expected_v0), .start(start),
      .running(running), .done(done), .pass(pass), .fail_code(fail_code),
      .cycle_count(cycle_count), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int idx, input logic [31:0] data);
      load_en    = 1'b1;
      load_index = idx[$clog2(DEPTH)-1:0];
      load_data  = data;
      tick();
      load_en    = 1'b0;
   endtask

   // Drive one fetch for a full cycle; expected word goes through the scoreboard.
   task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] e;
      instr_address = addr;
      sb_q.push_back(exp);
      @(negedge clk);
      e = sb_q.pop_front();
      check(name, instr_readdata, e);
      tick();
   endtask

   task automatic pulse_start(input logic [31:0] v);
      expected_v0 = v;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   // bltzal program trace: w0,w1,w2,w3(delay slot),w5(target),w6(jr),w7(slot), then halt.
   task automatic run_prog(input logic [31:0] exp_v0, input string tag);
      int trace [7] = '{0, 1, 2, 3, 5, 6, 7};
      register_v0   = 32'd2;
      instr_address = RV;
      pulse_start(exp_v0);
      check({tag, "_running"}, 32'(running), 32'd1);
      foreach (trace[i]) fetch({tag, "_fetch"}, RV + 32'(4 * trace[i]), prog[trace[i]]);
      fetch({tag, "_halt_fetch"}, 32'h0, 32'h0);
      check({tag, "_settle_running"}, 32'(running), 32'd1);
      repeat (SETTLE_CYCLES - 1) tick();
      check({tag, "_not_done_early"}, 32'(done), 32'd0);
      tick();
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_fetch_count"}, 32'(fetch_count), 32'd7);
   endtask

   initial begin
      int n;
      prog = '{32'h2404FFFF, 32'h00001023, 32'h04900002, 32'h24420001,
               32'h24420001, 32'h24420001, 32'h00000008, 32'h00000000};
      vecs = '{
         '{"rd_word0",      RV,                    prog[0]},
         '{"rd_word7",      RV + 32'd28,           prog[7]},
         '{"rd_last_word",  RV + 32'(4*DEPTH - 4), MARKER},
         '{"rd_misaligned", RV + 32'd2,            32'h0},
         '{"rd_below",      RV - 32'd4,            32'h0},
         '{"rd_past_end",   RV + 32'(4*DEPTH),     32'h0},
         '{"rd_zero",       32'h0,                 32'h0}
      };

      reset = 1'b0; instr_address = 32'h0; register_v0 = 32'h0;
      load_en = 1'b0; load_index = '0; load_data = 32'h0;
      expected_v0 = 32'h0; start = 1'b0;
      #1;
      check("rst_running", 32'(running), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_fail_code", 32'(fail_code), 32'd0);
      check("rst_cycle_count", 32'(cycle_count), 32'd0);
      check("rst_fetch_count", 32'(fetch_count), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      foreach (prog[i]) load(i, prog[i]);
      load(DEPTH - 1, MARKER);

      foreach (vecs[i]) fetch(vecs[i].name, vecs[i].addr, vecs[i].data);

      run_prog(32'd2, "t1");
      check("t1_pass", 32'(pass), 32'd1);
      check("t1_fail_code", 32'(fail_code), 32'd0);

      run_prog(32'd3, "t2");
      check("t2_pass", 32'(pass), 32'd0);
      check("t2_fail_code", 32'(fail_code), 32'd1);

      // Writes blocked in RUN; start in SETTLE does not restart the run.
      instr_address = RV;
      pulse_start(32'd2);
      fetch("t6_fetch0", RV, prog[0]);
      load_en = 1'b1; load_index = '0; load_data = 32'hDEADBEEF;
      fetch("t6_fetch1", RV + 32'd4, prog[1]);
      load_en = 1'b0;
      fetch("t6_word0_kept", RV, prog[0]);
      fetch("t6_halt", 32'h0, 32'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("t6_pass", 32'(pass), 32'd1);
      tick();
      check("t6_pass_held", 32'(pass), 32'd1);
      check("t6_not_running", 32'(running), 32'd0);

      instr_address = RV;
      pulse_start(32'd2);
      fetch("t4_fetch0", RV, prog[0]);
      fetch("t4_fetch1", RV + 32'd4, prog[1]);
      check("t4_still_running", 32'(running), 32'd1);
      fetch("t4_bad_fetch_data", RV + 32'(4*DEPTH), 32'h0);
      check("t4_done", 32'(done), 32'd1);
      check("t4_pass", 32'(pass), 32'd0);
      check("t4_fail_code", 32'(fail_code), 32'd3);

      instr_address = RV;
      pulse_start(32'd2);
      fetch("t5_fetch0", RV, prog[0]);
      fetch("t5_fetch1", RV + 32'd4, prog[1]);
      #2;
      reset = 1'b0;
      #1;
      check("t5_running", 32'(running), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_cycle_count", 32'(cycle_count), 32'd0);
      check("t5_fetch_count", 32'(fetch_count), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      fetch("t5_readback", RV + 32'd4, prog[1]);
      check("t5_idle", 32'(running), 32'd0);

      load(0, J_SELF);
      instr_address = RV;
      pulse_start(32'd0);
      n = 0;
      while (!done && n < 80) begin
         fetch("t3_fetch", RV, J_SELF);
         n++;
      end
      check("t3_done", 32'(done), 32'd1);
      check("t3_run_cycles", 32'(n), 32'd50);
      check("t3_fail_code", 32'(fail_code), 32'd2);
      check("t3_cycle_count", 32'(cycle_count), 32'd49);
      check("t3_fetch_count", 32'(fetch_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
